// File: rtl/ae_seq_core.sv
// Self-sequencing fixed-point compute core: host-loaded program, FETCH/EXEC/WB sequencer, MAC and activations.
// Build option: define AE_SAT_EN to saturate ADD/SUB/MUL/MAC/DEC instead of wrapping.
module ae_seq_core #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int REG_AW = 4,
    parameter int PC_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [15:0]       prog_data,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_DONE} state_t;

    localparam int NREG  = 1 << REG_AW;
    localparam int NPROG = 1 << PC_W;
    // Wide enough for any full product plus an accumulate without overflow.
    localparam int XW    = 2 * DATA_W + 2;
    localparam logic signed [XW-1:0] C_LSB  = XW'(1);
    localparam logic signed [XW-1:0] C_ONE  = C_LSB <<< FRAC_W;
    localparam logic signed [XW-1:0] C_HALF = C_LSB <<< (FRAC_W - 1);
`ifdef AE_SAT_EN
    localparam logic signed [XW-1:0] C_MAX  = (C_LSB <<< (DATA_W - 1)) - C_LSB;
    localparam logic signed [XW-1:0] C_MIN  = -(C_LSB <<< (DATA_W - 1));
`endif

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [15:0]         r_ir;
    logic [DATA_W-1:0]   r_res;
    logic                r_take;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_host_rdata;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic [15:0]         r_prog [NPROG];

    logic [3:0]               w_op;
    logic [REG_AW-1:0]        w_src1;
    logic [REG_AW-1:0]        w_src2;
    logic [REG_AW-1:0]        w_dst;
    logic signed [DATA_W-1:0] w_s1;
    logic signed [DATA_W-1:0] w_s2;
    logic signed [DATA_W-1:0] w_sd;
    logic signed [XW-1:0]     w_a;
    logic signed [XW-1:0]     w_b;
    logic signed [XW-1:0]     w_d;
    logic signed [XW-1:0]     w_mul;
    logic signed [XW-1:0]     w_hs;
    logic [DATA_W-1:0]        w_result;
    logic                     w_writes;
    logic                     w_take;
    logic [7:0]               w_target8;
    logic [PC_W-1:0]          w_target;

    function automatic logic [DATA_W-1:0] fit(input logic signed [XW-1:0] v);
`ifdef AE_SAT_EN
        if (v > C_MAX) return C_MAX[DATA_W-1:0];
        if (v < C_MIN) return C_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] trunc(input logic signed [XW-1:0] v);
        return v[DATA_W-1:0];
    endfunction

    assign w_op      = r_ir[15:12];
    assign w_src1    = r_ir[8 +: REG_AW];
    assign w_src2    = r_ir[4 +: REG_AW];
    assign w_dst     = r_ir[0 +: REG_AW];
    assign w_s1      = r_regs[w_src1];
    assign w_s2      = r_regs[w_src2];
    assign w_sd      = r_regs[w_dst];
    assign w_a       = {{(XW-DATA_W){w_s1[DATA_W-1]}}, w_s1};
    assign w_b       = {{(XW-DATA_W){w_s2[DATA_W-1]}}, w_s2};
    assign w_d       = {{(XW-DATA_W){w_sd[DATA_W-1]}}, w_sd};
    assign w_mul     = (w_a * w_b) >>> FRAC_W;
    assign w_writes  = (w_op >= 4'h1) && (w_op <= 4'h8);
    assign w_take    = (w_op == 4'h9) && (w_s1 != '0);
    assign w_target8 = r_ir[7:0];
    assign w_target  = w_target8[PC_W-1:0];

    always_comb begin
        w_hs     = (w_a >>> 2) + C_HALF;
        w_result = '0;
        case (w_op)
            4'h1: w_result = fit(w_a + w_b);
            4'h2: w_result = fit(w_a - w_b);
            4'h3: w_result = fit(w_mul);
            4'h4: w_result = fit(w_d + w_mul);
            4'h5: w_result = w_s1[DATA_W-1] ? '0 : w_s1;
            4'h6: begin
                if (w_hs[XW-1])      w_result = '0;
                else if (w_hs > C_ONE) w_result = C_ONE[DATA_W-1:0];
                else                 w_result = w_hs[DATA_W-1:0];
            end
            4'h7: w_result = trunc((w_a * (C_ONE - w_a)) >>> FRAC_W);
            4'h8: w_result = fit(w_a - C_LSB);
            default: w_result = '0;
        endcase
    end

    // Program memory has no reset so a reset mid-run leaves the loaded program intact.
    always_ff @(posedge clock) begin
        if (prog_we && (r_state == S_IDLE)) r_prog[prog_addr] <= prog_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_res        <= '0;
            r_take       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_host_rdata <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_host_rdata <= r_regs[host_addr];
            r_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (host_we) r_regs[host_addr] <= host_wdata;
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_ir    <= r_prog[r_pc];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res  <= w_result;
                    r_take <= w_take;
                    if (w_op == 4'hF) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (w_writes) r_regs[w_dst] <= r_res;
                    if (r_take) begin
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                    end else if (r_pc == '1) begin
                        // Falling off the end of program memory is an error, not a wrap.
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_pc    <= r_pc + 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign host_rdata = r_host_rdata;
    assign dbg_state  = r_state;
endmodule

// File: tb/tb_ae_seq_core.sv
// Bench for ae_seq_core: instruction-level reference model, per-cycle handshake monitor, register readback.
module tb_ae_seq_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        host_we = 1'b0;
    logic [3:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic [15:0] host_rdata;
    logic [2:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] m_regs [16];
    logic [15:0] m_prog [32];
    logic [15:0] exp_q [$];

    bit mon_active  = 1'b0;
    int mon_k       = 0;
    int mon_len     = 0;
    bit mon_err_exp = 1'b0;
    int dut_done_k  = -1;

    ae_seq_core dut (
        .clock(clk), .reset(rst), .start(start), .busy(busy), .done(done), .err(err),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic logic [15:0] fit(input longint v);
`ifdef AE_SAT_EN
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    task automatic model_run(output int len, output bit e);
        int pc, n, op;
        logic [15:0] ins;
        longint a, b, d, h, p;
        bit taken;
        pc = 0; n = 0; len = -1; e = 1'b0;
        for (int step = 0; step < 4000; step++) begin
            ins = m_prog[pc];
            op  = int'(ins[15:12]);
            if (op == 15) begin len = 3 * n + 3; return; end
            a = sx(m_regs[ins[11:8]]);
            b = sx(m_regs[ins[7:4]]);
            d = sx(m_regs[ins[3:0]]);
            n++;
            taken = 1'b0;
            case (op)
                1: m_regs[ins[3:0]] = fit(a + b);
                2: m_regs[ins[3:0]] = fit(a - b);
                3: m_regs[ins[3:0]] = fit((a * b) >>> 8);
                4: m_regs[ins[3:0]] = fit(d + ((a * b) >>> 8));
                5: m_regs[ins[3:0]] = (a < 0) ? 16'h0000 : a[15:0];
                6: begin
                    h = (a >>> 2) + 128;
                    if (h < 0) h = 0;
                    if (h > 256) h = 256;
                    m_regs[ins[3:0]] = h[15:0];
                end
                7: begin
                    p = (a * (256 - a)) >>> 8;
                    m_regs[ins[3:0]] = p[15:0];
                end
                8: m_regs[ins[3:0]] = fit(a - 1);
                9: taken = (a != 0);
                default: ;
            endcase
            if (taken) pc = int'(ins[4:0]);
            else if (pc == 31) begin e = 1'b1; len = 3 * n + 1; return; end
            else pc++;
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (mon_active) begin
                mon_k++;
                if (done && dut_done_k < 0) dut_done_k = mon_k;
                if (mon_k < mon_len) begin
                    chk("busy_run", busy, 1);
                    chk("done_run", done, 0);
                    chk("err_run", err, 0);
                end else begin
                    chk("busy_at_done", busy, 0);
                    chk("done_pulse", done, 1);
                    chk("err_at_done", err, mon_err_exp);
                    mon_active = 1'b0;
                end
            end else begin
                chk("busy_idle", busy, 0);
                chk("done_idle", done, 0);
                chk("err_idle", err, mon_err_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        m_regs[a] = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic load_prog(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        m_prog[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        v = host_rdata;
    endtask

    task automatic check_all_regs(input string name);
        logic [15:0] v, e;
        for (int i = 0; i < 16; i++) exp_q.push_back(m_regs[i]);
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            e = exp_q.pop_front();
            chk($sformatf("%s_r%0d", name, i), v, e);
        end
    endtask

    task automatic run_prog(input bit disturb, input int abort_at);
        int len;
        bit e;
        model_run(len, e);
        if (len < 0) begin
            $display("FAIL model: program did not terminate");
            $fatal(1);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        mon_len = len; mon_k = 0; mon_err_exp = e; dut_done_k = -1; mon_active = 1'b1;
        #1 start = 1'b0;
        for (int k = 1; k <= len + 2; k++) begin
            @(negedge clk);
            if (abort_at == k) return;
            if (disturb && k == 2) begin
                start = 1'b1;
                host_we = 1'b1; host_addr = 4'd7; host_wdata = 16'h1234;
                prog_we = 1'b1; prog_addr = 5'd1; prog_data = 16'h0000;
            end else if (disturb && k == 3) begin
                start = 1'b0; host_we = 1'b0; prog_we = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_active = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_state", dbg_state, 0);
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        mon_err_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] v;
        logic [15:0] w;
        int op;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
        for (int i = 0; i < 32; i++) m_prog[i] = 16'h0000;

        repeat (3) @(negedge clk);
        do_reset();
        check_all_regs("reset");

        // same-cycle host read and write returns the old value
        write_reg(4'd5, 16'h1111);
        @(negedge clk);
        host_addr = 4'd5; host_we = 1'b1; host_wdata = 16'h2222;
        @(negedge clk);
        host_we = 1'b0;
        chk("rw_same_old", host_rdata, 16'h1111);
        @(negedge clk);
        chk("rw_same_new", host_rdata, 16'h2222);
        m_regs[5] = 16'h2222;

        // MUL
        write_reg(4'd0, 16'h0180);
        write_reg(4'd1, 16'h0200);
        load_prog(5'd0, 16'h3012);
        load_prog(5'd1, 16'hF000);
        run_prog(1'b0, 0);
        chk("mul_done_cycle", dut_done_k, 6);
        read_reg(4'd2, v);
        chk("mul_r2", v, 16'h0300);
        check_all_regs("mul");

        // start/host/program writes while busy are dropped
        run_prog(1'b1, 0);
        chk("busy_writes_done_cycle", dut_done_k, 6);
        check_all_regs("busy_writes");

        // ADD overflow
        write_reg(4'd0, 16'h7F00);
        write_reg(4'd1, 16'h0200);
        load_prog(5'd0, 16'h1012);
        run_prog(1'b0, 0);
        read_reg(4'd2, v);
`ifdef AE_SAT_EN
        chk("add_sat_r2", v, 16'h7FFF);
`else
        chk("add_wrap_r2", v, 16'h8100);
`endif
        check_all_regs("add");

        // activations
        write_reg(4'd0, 16'hFF00);
        write_reg(4'd3, 16'h0000);
        write_reg(4'd4, 16'h0080);
        load_prog(5'd0, 16'h5002);
        load_prog(5'd1, 16'h6305);
        load_prog(5'd2, 16'h7406);
        load_prog(5'd3, 16'hF000);
        run_prog(1'b0, 0);
        chk("act_done_cycle", dut_done_k, 12);
        read_reg(4'd2, v);
        chk("relu_r2", v, 16'h0000);
        read_reg(4'd5, v);
        chk("hsig_r5", v, 16'h0080);
        read_reg(4'd6, v);
        chk("dsig_r6", v, 16'h0040);
        check_all_regs("act");

        // MAC with dst aliasing src2
        write_reg(4'd0, 16'h0100);
        write_reg(4'd1, 16'h0200);
        load_prog(5'd0, 16'h4011);
        load_prog(5'd1, 16'hF000);
        run_prog(1'b0, 0);
        read_reg(4'd1, v);
        chk("mac_alias_r1", v, 16'h0400);

        // loop
        write_reg(4'd1, 16'd3);
        load_prog(5'd0, 16'h8101);
        load_prog(5'd1, 16'h9100);
        load_prog(5'd2, 16'hF000);
        run_prog(1'b0, 0);
        chk("loop_done_cycle", dut_done_k, 21);
        read_reg(4'd1, v);
        chk("loop_r1", v, 16'h0000);
        check_all_regs("loop");

        // PC overflow
        for (int i = 0; i < 32; i++) load_prog(5'(i), 16'h0000);
        run_prog(1'b0, 0);
        chk("ovf_done_cycle", dut_done_k, 97);
        @(negedge clk);
        chk("ovf_err_sticky", err, 1);
        do_reset();
        @(negedge clk);
        chk("ovf_err_after_reset", err, 0);

        // randomized programs, forward-only jumps so every program terminates
        for (int t = 0; t < 24; t++) begin
            for (int j = 0; j < 6; j++) begin
                if ($urandom_range(0, 1) == 1) v = 16'($urandom_range(0, 65535));
                else v = 16'(int'($urandom_range(0, 1023)) - 512);
                write_reg(4'($urandom_range(0, 15)), v);
            end
            for (int i = 0; i < 32; i++) begin
                op = int'($urandom_range(0, 15));
                if (op == 9 && i == 31) op = 8;
                w = {4'(op), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
                if (op == 9) w[4:0] = 5'($urandom_range(i + 1, 31));
                load_prog(5'(i), w);
            end
            run_prog(1'b0, 0);
            check_all_regs($sformatf("rand%0d", t));
        end

        // reset mid-program, then rerun the untouched program
        load_prog(5'd0, 16'h8101);
        load_prog(5'd1, 16'h9100);
        load_prog(5'd2, 16'hF000);
        write_reg(4'd1, 16'd20);
        run_prog(1'b0, 7);
        do_reset();
        check_all_regs("midrun_reset");
        write_reg(4'd1, 16'd3);
        run_prog(1'b0, 0);
        chk("rerun_done_cycle", dut_done_k, 21);
        read_reg(4'd1, v);
        chk("rerun_r1", v, 16'h0000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ae_seq_core.md
# ae_seq_core

Parametrised, self-sequencing autoencoder compute core. It generalises the fixed 16-bit fetch/ALU/demux/activation datapath into a single block with the following features:
- configurable data width, fixed-point format, register-file depth and program depth;
- a host-loadable program memory;
- a start/done handshake;
- MAC, a loop branch and on-chip activation ops: ReLU, hard-sigmoid and sigmoid-derivative.

It sits under the training/inference top level. The host loads weights and the program, pulses `start`, waits for `done`, then reads results back.

## Interface
Parameters:
- `DATA_W`, 16, operand/register width, signed two's complement
- `FRAC_W`, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
- `REG_AW`, 4, register-file address width; depth = 2^REG_AW, max 4
- `PC_W`, 5, program counter width; program depth = 2^PC_W

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle pulse; honoured only in IDLE
- `busy`  out  1  high in FETCH/EXEC/WB
- `done`  out  1  one-cycle pulse when a HALT completes or an error occurs
- `err`  out  1  sticky; set on PC overflow; cleared by the next accepted `start`
- `prog_we`  in  1  program write strobe; ignored unless IDLE
- `prog_addr`  in  PC_W  program write address
- `prog_data`  in  16  instruction word
- `host_we`  in  1  register-file write strobe; ignored unless IDLE
- `host_addr`  in  REG_AW  register read/write address
- `host_wdata`  in  DATA_W  register write data
- `host_rdata`  out  DATA_W  registered read of `reg[host_addr]`; valid in any state

## Operation
Instruction format:
- `[15:12]` op, `[11:8]` src1, `[7:4]` src2, `[3:0]` dst.
- Register fields use their low REG_AW bits.

Opcodes:
- 0 NOP
- 1 ADD: dst = s1 + s2
- 2 SUB: dst = s1 - s2
- 3 MUL: dst = (s1 * s2) >>> FRAC_W, full 2·DATA_W product, arithmetic shift
- 4 MAC: dst = dst + ((s1 * s2) >>> FRAC_W)
- 5 RELU: dst = s1 < 0 ? 0 : s1
- 6 HSIG: dst = clamp((s1 >>> 2) + 2^(FRAC_W-1), 0, 2^FRAC_W)
- 7 DSIG: dst = (s1 * (2^FRAC_W - s1)) >>> FRAC_W
- 8 DEC: dst = s1 - 1 (integer LSB)
- 9 JNZ: if reg[src1] != 0 then PC = {src2, dst}[PC_W-1:0], else PC + 1; no register write
- F HALT
- A–E execute as NOP.

FSM:
- IDLE: on `start`, go to FETCH with PC = 0 and `err` cleared.
- FETCH: IR <= prog[PC], go to EXEC.
- EXEC: read operands combinationally, register the result. If op = HALT, go to DONE; otherwise go to WB.
- WB:
  - Write the result to dst for ops 1–8.
  - Update PC: the JNZ target, or PC + 1.
  - If PC = 2^PC_W - 1 and the next PC is sequential (not a taken JNZ), set `err` and go to DONE; otherwise go to FETCH.
- DONE: `done` = 1 for one cycle, then go to IDLE.

Boundary rules:
- `start` while not IDLE is ignored.
- Host and program writes while not IDLE are dropped.
- MAC where dst equals src1 or src2 uses the pre-write values.
- Host read and write to the same address in the same IDLE cycle: `host_rdata` returns the old value.

## Timing
- Every non-HALT instruction takes exactly 3 cycles (FETCH, EXEC, WB). HALT takes FETCH, EXEC, then DONE.
- `start` sampled at edge t: FETCH occupies cycle t+1, and `busy` rises after edge t.
- Program of N non-HALT instructions followed by HALT: `done` is high in cycle t + 3N + 3; `busy` is low in that cycle.
- `host_rdata` latency is 1 cycle.
- Reset, asynchronous and valid at any point including mid-program:
  - state = IDLE, PC = 0, IR = 0;
  - `busy` = 0, `done` = 0, `err` = 0, `host_rdata` = 0;
  - all registers = 0.
- Program memory is not reset.

## Configuration
- Macro `AE_SAT_EN`.
- Defined: ADD, SUB, MUL, MAC and DEC saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Undefined: these ops wrap modulo 2^DATA_W.
- RELU, HSIG and DSIG behave identically in both builds.

## Test plan
All values use default parameters.
- MUL: r0 = 0x0180, r1 = 0x0200; program `3012`, `F000`; start → `done` 6 cycles after start, r2 = 0x0300.
- Saturation: r0 = 0x7F00, r1 = 0x0200; ADD → r2 = 0x7FFF with `AE_SAT_EN`, 0x8100 without.
- Activations: r0 = 0xFF00 → RELU gives 0x0000. r0 = 0x0000 → HSIG gives 0x0080. r0 = 0x0080 → DSIG gives 0x0040.
- Loop: r1 = 3; program `8101` (DEC r1), `9100` (JNZ r1 to 0), `F000` → r1 = 0, `done` 21 cycles after start.
- Overflow and reset:
  - 32 NOPs with no HALT → `err` = 1, `done` pulses.
  - Asserting `reset` mid-program → `busy`, `done`, `err`, `host_rdata` and all registers read 0; program memory is intact, and a new `start` reruns the program correctly.
